// File: rtl/max_pool_stream_if.sv
// max_pool_stream_if: valid/ready/data stream bundle.
// master drives valid+data, slave drives ready.
interface max_pool_stream_if #(
  parameter int DATA_W = 20
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming 2x2 stride-2 max pooling.
// Define MAXPOOL_SIGNED_EN for signed compare (default unsigned).
module max_pool_stream #(
  parameter int DATA_W = 20,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic             clk,
  input  logic             rst,
  max_pool_stream_if.slave  in_s,
  max_pool_stream_if.master out_m,
  output logic             frame_done
);
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW = $clog2(IMG_H);
  localparam int LD = IMG_W / 2;

  typedef logic [DATA_W-1:0] px_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  px_t           hold_q, hold_d;
  px_t           data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;

  px_t           linebuf [LD];
  logic          lb_we;
  px_t           lb_wdata;
  px_t           lb_rdata;
  logic [CW-2:0] lb_idx;

  logic acc, load;
  logic col_odd, row_odd, col_end, row_end;

  function automatic px_t pmax(px_t a, px_t b);
`ifdef MAXPOOL_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  assign in_s.ready = !valid_q || out_m.ready;
  assign acc        = in_s.valid && in_s.ready;
  assign col_odd    = col_q[0];
  assign row_odd    = row_q[0];
  assign col_end    = col_q == CW'(IMG_W - 1);
  assign row_end    = row_q == RW'(IMG_H - 1);
  assign lb_idx     = col_q[CW-1:1];
  assign lb_rdata   = linebuf[lb_idx];

  assign out_m.valid = valid_q;
  assign out_m.data  = data_q;
  assign frame_done  = valid_q && out_m.ready && last_q;

  // Position counters, even-row pair max and odd-row window assembly.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    hold_d   = hold_q;
    lb_we    = 1'b0;
    lb_wdata = pmax(hold_q, in_s.data);
    load     = 1'b0;
    if (acc) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      if (col_end) begin
        row_d = row_end ? '0 : row_q + 1'b1;
      end
      unique case ({row_odd, col_odd})
        2'b00:   hold_d = in_s.data;
        2'b01:   lb_we  = 1'b1;
        2'b10:   hold_d = pmax(lb_rdata, in_s.data);
        default: load   = 1'b1;
      endcase
    end
  end

  // Output register: load wins over drain in the same cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load) begin
      data_d  = pmax(hold_q, in_s.data);
      valid_d = 1'b1;
      last_d  = row_end && col_end;
    end else if (valid_q && out_m.ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Line buffer write; never read before an even row rewrites it.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf[lb_idx] <= lb_wdata;
    end
  end
endmodule

// File: tb/tb_max_pool_stream.sv
// tb_max_pool_stream: vector table, corner sequences and
// randomized frames checked against a window-max model.
module tb_max_pool_stream;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NP = W * H;

`ifdef MAXPOOL_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  typedef logic [DW-1:0] px_t;
  typedef struct {
    px_t a, b, c, d;
    px_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic frame_done;

  always #5 clk = ~clk;

  max_pool_stream_if #(.DATA_W(DW)) in_if ();
  max_pool_stream_if #(.DATA_W(DW)) out_if ();

  max_pool_stream #(
    .DATA_W(DW),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_s      (in_if),
    .out_m     (out_if),
    .frame_done(frame_done)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  px_t pix_q[$];
  px_t exp_q[$];
  px_t got_q[$];
  bit  fd_q[$];
  int  lat_bad, bp_bad, bubbles, fd_bad, held;

  task automatic check(input string nm, input longint act,
                       input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic px_t mx(px_t a, px_t b);
    if (SGN) return ($signed(a) > $signed(b)) ? a : b;
    return (a > b) ? a : b;
  endfunction

  // Reference: every 2x2 window of each frame, raster order.
  task automatic build_exp();
    exp_q.delete();
    for (int f = 0; f < pix_q.size() / NP; f++)
      for (int r = 0; r < H; r += 2)
        for (int c = 0; c < W; c += 2) begin
          int b = f * NP + r * W + c;
          exp_q.push_back(mx(mx(pix_q[b], pix_q[b+1]),
                             mx(pix_q[b+W], pix_q[b+W+1])));
        end
  endtask

  // mode 0: full rate; 1: random gaps/backpressure;
  // 2: 5-cycle stall on the first output.
  task automatic run(input int mode);
    int idx = 0, cyc = 0, tail = 0;
    int acc_cyc[$];
    got_q.delete();
    fd_q.delete();
    lat_bad = 0; bp_bad = 0; bubbles = 0; fd_bad = 0; held = 0;
    @(posedge clk);
    #1;
    while (cyc < 3000) begin
      in_if.valid = (idx < pix_q.size()) &&
                    (mode != 1 || $urandom_range(0, 3) != 0);
      in_if.data = (idx < pix_q.size()) ? pix_q[idx]
                                        : px_t'($urandom);
      if (mode == 1) out_if.ready = $urandom_range(0, 2) != 0;
      else if (mode == 2) out_if.ready = !(out_if.valid && held < 5);
      else out_if.ready = 1'b1;
      @(negedge clk);
      if (mode == 0 && in_if.valid && !in_if.ready) bubbles++;
      if (mode == 2 && out_if.valid && !out_if.ready) begin
        held++;
        if (in_if.ready || out_if.data != exp_q[0]) bp_bad++;
      end
      if (in_if.valid && in_if.ready) begin
        if ((idx % W) % 2 == 1 && ((idx / W) % H) % 2 == 1)
          acc_cyc.push_back(cyc);
        idx++;
      end
      if (out_if.valid && out_if.ready) begin
        got_q.push_back(out_if.data);
        fd_q.push_back(frame_done);
        if (mode == 0) begin
          if (acc_cyc.size() == 0) lat_bad++;
          else if (acc_cyc.pop_front() + 1 != cyc) lat_bad++;
        end
      end else if (frame_done) begin
        fd_bad++;
      end
      cyc++;
      if (idx == pix_q.size() && !out_if.valid) tail++;
      if (tail >= 3) break;
      @(posedge clk);
      #1;
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    check("timeout", cyc < 3000, 1);
    check("stray_frame_done", fd_bad, 0);
  endtask

  task automatic check_model(input string nm);
    int n;
    check({nm, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", nm, i), got_q[i], exp_q[i]);
      check($sformatf("%s_fd%0d", nm, i), fd_q[i],
            (i % ((W / 2) * (H / 2))) == (W / 2) * (H / 2) - 1);
    end
  endtask

  task automatic check_const(input string nm, input px_t k[4]);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_k%0d", nm, i),
            (i < got_q.size()) ? got_q[i] : 'x, k[i]);
  endtask

  task automatic ramp();
    pix_q.delete();
    for (int i = 0; i < NP; i++) pix_q.push_back(px_t'(i));
  endtask

  vec_t tbl[7];
  px_t  k_ramp[4] = '{8'd5, 8'd7, 8'd13, 8'd15};
  px_t  k_rows[4] = '{8'd9, 8'd8, 8'd0, 8'd0};

  initial begin
    tbl[0] = '{8'hFF, 8'h01, 8'h01, 8'h01, SGN ? 8'h01 : 8'hFF};
    tbl[1] = '{8'h80, 8'h7F, 8'h00, 8'h01, SGN ? 8'h7F : 8'h80};
    tbl[2] = '{8'h09, 8'h01, 8'h03, 8'h04, 8'h09};
    tbl[3] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    tbl[4] = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h07};
    tbl[5] = '{8'h10, 8'h20, 8'h30, 8'h05, 8'h30};
    tbl[6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    rst = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_if.valid, 0);
    check("rst_out_data", out_if.data, 0);
    check("rst_in_ready", in_if.ready, 1);
    check("rst_frame_done", frame_done, 0);

    ramp();
    build_exp();
    run(0);
    check_const("ramp", k_ramp);
    check_model("ramp");
    check("ramp_latency", lat_bad, 0);
    check("ramp_bubbles", bubbles, 0);

    pix_q = '{9, 1, 2, 8, 3, 4, 6, 5, 0, 0, 0, 0, 0, 0, 0, 0};
    build_exp();
    run(0);
    check_const("rows", k_rows);

    foreach (tbl[t]) begin
      pix_q.delete();
      for (int i = 0; i < NP; i++) pix_q.push_back('0);
      pix_q[0] = tbl[t].a;
      pix_q[1] = tbl[t].b;
      pix_q[W] = tbl[t].c;
      pix_q[W+1] = tbl[t].d;
      run(0);
      check($sformatf("tbl%0d", t),
            (got_q.size() > 0) ? got_q[0] : 'x, tbl[t].e);
    end

    ramp();
    build_exp();
    run(2);
    check_const("stall", k_ramp);
    check("stall_cycles", held, 5);
    check("stall_hold", bp_bad, 0);

    @(posedge clk);
    #1 out_if.ready = 1'b0;
    for (int i = 0, n = 0; i < 6 && n < 40; n++) begin
      in_if.valid = 1'b1;
      in_if.data  = px_t'(i);
      @(negedge clk);
      if (in_if.ready) i++;
      @(posedge clk);
      #1;
    end
    in_if.valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_if.ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_if.valid, 0);
    check("midrst_out_data", out_if.data, 0);
    ramp();
    build_exp();
    run(0);
    check("midrst_count", got_q.size(), 4);
    check_const("midrst", k_ramp);

    ramp();
    for (int i = 0; i < NP; i++) pix_q.push_back(px_t'(i));
    build_exp();
    run(0);
    check_model("b2b");
    check("b2b_fd_total", fd_q.sum() with (int'(item)), 2);
    check("b2b_bubbles", bubbles, 0);
    check("b2b_latency", lat_bad, 0);

    for (int r = 0; r < 6; r++) begin
      pix_q.delete();
      for (int i = 0; i < NP * (1 + r % 2); i++)
        pix_q.push_back(px_t'($urandom));
      build_exp();
      run(1);
      check_model($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
